// File: rtl/half_pkg.sv
// Shared binary16 types, constants and unpack helper for the half-precision datapath stages.
package half_pkg;

  localparam int unsigned HALF_W   = 16;
  localparam int unsigned EXP_W    = 5;
  localparam int unsigned MAN_W    = 10;
  localparam int unsigned EXP_BIAS = 15;
  localparam int unsigned EXP_MAX  = 31;
  localparam int unsigned SIG_W    = MAN_W + 1;
  localparam int unsigned SUM_W    = SIG_W + 1;
  localparam logic [14:0] HALF_SAT_MAG = 15'h7FFF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] mant;
  } half_t;

  typedef struct {
    logic              sign;
    logic signed [6:0] exp;
    logic [SUM_W-1:0]  sig;
  } half_work_t;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_ALIGN,
    ACC_ADD,
    ACC_NORM
  } acc_state_e;

  // exp==0 (zero or subnormal) is flushed to +0; otherwise hidden 1 is restored.
  function automatic half_work_t half_unpack(input half_t h);
    half_work_t w;
    if (h.exp == '0) begin
      w.sign = 1'b0;
      w.exp  = 7'sd0;
      w.sig  = '0;
    end else begin
      w.sign = h.sign;
      w.exp  = 7'(h.exp);
      w.sig  = {1'b0, 1'b1, h.mant};
    end
    return w;
  endfunction

endpackage

// File: rtl/half_accumulate_if.sv
// Product-stream input and frame-sum output bundle of the half-precision accumulator.
interface half_accumulate_if
  import half_pkg::*;
#(
  parameter int unsigned CNT_W = 8
);
  logic              in_valid;
  logic [HALF_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              out_valid;
  logic [HALF_W-1:0] c;
  logic [CNT_W-1:0]  out_count;
  logic              overflow;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, out_valid, c, out_count, overflow
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, out_valid, c, out_count, overflow
  );
endinterface

// File: rtl/half_sync_fifo.sv
// Small synchronous FIFO with registered write and combinational head read.
module half_sync_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/half_accumulate.sv
// Frame-wise binary16 summation: input FIFO feeding a 3-cycle align/add/normalize loop.
module half_accumulate
  import half_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rstn,
  half_accumulate_if.slave   bus
);
  localparam int unsigned FW = HALF_W + 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic signed [6:0] EXP_MAX_S = 7'(EXP_MAX);

  acc_state_e        state_q, state_d;
  half_t             acc_q, acc_d, elem_q, elem_d;
  logic              elem_last_q, elem_last_d;
  logic              x_sign_q, x_sign_d, sub_q, sub_d;
  logic [EXP_W-1:0]  x_exp_q, x_exp_d;
  logic [SUM_W-1:0]  x_sig_q, x_sig_d, y_sig_q, y_sig_d, sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc, out_count_q, out_count_d;
  logic [HALF_W-1:0] c_q, c_d;
  logic              out_valid_q, out_valid_d, overflow_q, overflow_d;

  logic [FW-1:0]     fifo_rdata;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0]     fifo_count;
  half_work_t        a_w, b_w, x_w, y_w;
  logic [6:0]        shift_amt;
  half_t             norm_res;

  half_sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (bus.in_valid),
    .wdata ({bus.in_last, bus.in_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.in_ready  = (fifo_count != CW'(FIFO_DEPTH));
  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign bus.out_count = out_count_q;
  assign bus.overflow  = overflow_q;

  function automatic logic [3:0] lzc11(input logic [SIG_W-1:0] v);
    logic [3:0] n;
    logic       found;
    n     = 4'd11;
    found = 1'b0;
    for (int i = SIG_W - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 4'(SIG_W - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Carry or leading-zero normalise, then flush (exp<=0) or saturate (exp>31).
  function automatic half_t norm_half(input logic sign, input logic [EXP_W-1:0] exp_in,
                                      input logic [SUM_W-1:0] sum);
    logic signed [6:0] nexp;
    logic [SUM_W-1:0]  nsig;
    logic [3:0]        lz;
    half_t             r;
    nexp = 7'(exp_in);
    lz   = lzc11(sum[SIG_W-1:0]);
    if (sum[SUM_W-1]) begin
      nsig = sum >> 1;
      nexp = nexp + 7'sd1;
    end else begin
      nsig = sum << lz;
      nexp = nexp - signed'(7'(lz));
    end
    if (sum == '0 || nexp <= 7'sd0) begin
      r = '0;
    end else if (nexp > EXP_MAX_S) begin
      r = {sign, HALF_SAT_MAG};
    end else begin
      r = {sign, EXP_W'(nexp), MAN_W'(nsig)};
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    elem_d      = elem_q;
    elem_last_d = elem_last_q;
    x_sign_d    = x_sign_q;
    x_exp_d     = x_exp_q;
    x_sig_d     = x_sig_q;
    y_sig_d     = y_sig_q;
    sub_d       = sub_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    c_d         = c_q;
    out_count_d = out_count_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q | (bus.in_valid & fifo_full);
    fifo_pop    = 1'b0;

    // Operand ordering so that x always has the larger magnitude.
    a_w = half_unpack(acc_q);
    b_w = half_unpack(elem_q);
    if ({b_w.exp, b_w.sig} > {a_w.exp, a_w.sig}) begin
      x_w = b_w;
      y_w = a_w;
    end else begin
      x_w = a_w;
      y_w = b_w;
    end
    shift_amt = 7'(x_w.exp - y_w.exp);
    norm_res  = norm_half(x_sign_q, x_exp_q, sum_q);
    cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    unique case (state_q)
      ACC_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          elem_d      = half_t'(fifo_rdata[HALF_W-1:0]);
          elem_last_d = fifo_rdata[FW-1];
          state_d     = ACC_ALIGN;
        end
      end
      ACC_ALIGN: begin
        x_sign_d = x_w.sign;
        x_exp_d  = EXP_W'(x_w.exp);
        x_sig_d  = x_w.sig;
        y_sig_d  = (shift_amt >= 7'd11) ? '0 : (y_w.sig >> shift_amt);
        sub_d    = x_w.sign ^ y_w.sign;
        state_d  = ACC_ADD;
      end
      ACC_ADD: begin
        sum_d   = sub_q ? (x_sig_q - y_sig_q) : (x_sig_q + y_sig_q);
        state_d = ACC_NORM;
      end
      ACC_NORM: begin
        if (elem_last_q) begin
          c_d         = norm_res;
          out_count_d = cnt_inc;
          out_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
        end else begin
          acc_d = norm_res;
          cnt_d = cnt_inc;
        end
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          elem_d      = half_t'(fifo_rdata[HALF_W-1:0]);
          elem_last_d = fifo_rdata[FW-1];
          state_d     = ACC_ALIGN;
        end else begin
          state_d = ACC_IDLE;
        end
      end
      default: state_d = ACC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ACC_IDLE;
      acc_q       <= '0;
      elem_q      <= '0;
      elem_last_q <= 1'b0;
      x_sign_q    <= 1'b0;
      x_exp_q     <= '0;
      x_sig_q     <= '0;
      y_sig_q     <= '0;
      sub_q       <= 1'b0;
      sum_q       <= '0;
      cnt_q       <= '0;
      c_q         <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      elem_q      <= elem_d;
      elem_last_q <= elem_last_d;
      x_sign_q    <= x_sign_d;
      x_exp_q     <= x_exp_d;
      x_sig_q     <= x_sig_d;
      y_sig_q     <= y_sig_d;
      sub_q       <= sub_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      c_q         <= c_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end
endmodule

// File: tb/tb_half_accumulate.sv
// Scoreboard bench for half_accumulate: directed frames, expected sums queued at issue time.
module tb_half_accumulate;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  half_accumulate_if #(.CNT_W(8)) bus ();

  half_accumulate #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic [15:0] c;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   t_acc;
  int   n;

  always @(posedge clk) cyc++;

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rstn && bus.out_valid) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got c=%h count=%0d, required no output", bus.c, bus.out_count);
      end else begin
        mon_e = sb_q.pop_front();
        if (bus.c !== mon_e.c || bus.out_count !== mon_e.cnt) begin
          fails++;
          $display("FAIL frame_sum: got c=%h count=%0d, required c=%h count=%0d",
                   bus.c, bus.out_count, mon_e.c, mon_e.cnt);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic expect_frame(input logic [15:0] c, input logic [7:0] cnt);
    exp_t e;
    e.c   = c;
    e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  // Called at a negedge; obeys in_ready, returns at the negedge after acceptance.
  task automatic send(input logic [15:0] d, input logic l);
    int w = 0;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0, required 1");
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_force(input logic [15:0] d, input logic l);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending", 32'(sb_q.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_c", 32'(bus.c), 32'd0);
    chk("rst_out_count", 32'(bus.out_count), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Single element, latency from acceptance to visible pulse.
    expect_frame(16'h3C00, 8'd1);
    send(16'h3C00, 1'b1);
    t_acc = cyc;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(cyc - t_acc), 32'd4);
    drain();

    // Back-to-back frames, including exact cancellation.
    expect_frame(16'h4000, 8'd2);
    expect_frame(16'h0000, 8'd2);
    send(16'h3C00, 1'b0);
    send(16'h3C00, 1'b1);
    send(16'h4000, 1'b0);
    send(16'hC000, 1'b1);
    drain();

    // Alignment shift, truncation and subnormal flush.
    expect_frame(16'h3C01, 8'd2);
    expect_frame(16'h3C00, 8'd2);
    expect_frame(16'h3C00, 8'd2);
    send(16'h3C00, 1'b0); send(16'h1400, 1'b1);
    send(16'h3C00, 1'b0); send(16'h1000, 1'b1);
    send(16'h0200, 1'b0); send(16'h3C00, 1'b1);
    drain();

    // Swapped subtraction and underflow flush.
    expect_frame(16'hBC00, 8'd2);
    expect_frame(16'h0000, 8'd2);
    send(16'h3C00, 1'b0); send(16'hC000, 1'b1);
    send(16'h0700, 1'b0); send(16'h8400, 1'b1);
    drain();

    // Saturation, both signs.
    expect_frame(16'h7FFF, 8'd3);
    expect_frame(16'hFFFF, 8'd3);
    send(16'h7BFF, 1'b0); send(16'h7BFF, 1'b0); send(16'h7FFF, 1'b1);
    send(16'hFBFF, 1'b0); send(16'hFBFF, 1'b0); send(16'hFFFF, 1'b1);
    drain();

    // Burst obeying in_ready: 1+2+3+4+5+6 = 21.
    expect_frame(16'h4D40, 8'd6);
    send(16'h3C00, 1'b0); send(16'h4000, 1'b0); send(16'h4200, 1'b0);
    send(16'h4400, 1'b0); send(16'h4500, 1'b0); send(16'h4600, 1'b1);
    chk("burst_in_ready_full", 32'(bus.in_ready), 32'd0);
    drain();
    chk("burst_overflow", 32'(bus.overflow), 32'd0);

    // Burst ignoring in_ready: 8 pushed, two land while full and are dropped.
    expect_frame(16'h4700, 8'd7);
    for (int i = 0; i < 8; i++) send_force(16'h3C00, 1'b0);
    send(16'h3C00, 1'b1);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    drain();
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Reset while the element is in ADD.
    send(16'h4000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_c", 32'(bus.c), 32'd0);
    chk("midrst_out_count", 32'(bus.out_count), 32'd0);
    chk("midrst_overflow", 32'(bus.overflow), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (8) @(negedge clk);
    chk("midrst_c_held", 32'(bus.c), 32'd0);

    expect_frame(16'h3C00, 8'd1);
    send(16'h3C00, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
